// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed high windows with a low gap after each one.
// Events that arrive while busy are queued. PULSE_STRETCHER_RETRIGGER_EN makes HOLD triggers extend the window.
module pulse_stretcher #(
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int MAX_PENDING = 3,
   parameter int PW          = $clog2(MAX_PENDING + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          trigger_in,
   output logic          level_out,
   output logic          busy,
   output logic [PW-1:0] pending,
   output logic          done,
   output logic          overflow
);

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] PMAX    = PW'(MAX_PENDING);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pend_q, pend_d;
   logic          level_q, level_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          inc, dec, retrig, hold_q_trig;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
   assign retrig      = trigger_in;
   assign hold_q_trig = 1'b0;
`else
   assign retrig      = 1'b0;
   assign hold_q_trig = trigger_in;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      done_d  = 1'b0;
      inc     = 1'b0;
      dec     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (trigger_in) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
               level_d = 1'b1;
            end
         end
         S_HOLD: begin
            inc = hold_q_trig;
            if (retrig) begin
               cnt_d = HOLD_LD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = S_GAP;
               cnt_d   = GAP_LD;
               level_d = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
               inc   = trigger_in;
            end else if (pend_q != '0) begin
               // Replay a queued event; a same-edge trigger takes its slot.
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
               level_d = 1'b1;
               dec     = 1'b1;
               inc     = trigger_in;
            end else if (trigger_in) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
               level_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      ovf_d  = 1'b0;
      if (inc && !dec) begin
         if (pend_q == PMAX) ovf_d = 1'b1;
         else                pend_d = pend_q + PW'(1);
      end else if (dec && !inc) begin
         pend_d = pend_q - PW'(1);
      end
   end

   assign busy_d = (state_d != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         level_q <= level_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign level_out = level_q;
   assign busy      = busy_q;
   assign pending   = pend_q;
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD=4, GAP=2, MAX_PENDING=2.
// Each scenario lists per-cycle expected outputs as strings, index 0 = trigger edge.
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trigger_in = 1'b0;
   logic       level_out, busy, done, overflow;
   logic [1:0] pending;

   int n_chk = 0;
   int n_err = 0;

   pulse_stretcher #(
      .HOLD_CYCLES(4),
      .GAP_CYCLES (2),
      .MAX_PENDING(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .trigger_in(trigger_in),
      .level_out (level_out),
      .busy      (busy),
      .pending   (pending),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".level"}, int'(level_out), 0);
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".pend"}, int'(pending), 0);
      check({tag, ".done"}, int'(done), 0);
      check({tag, ".ovf"}, int'(overflow), 0);
   endtask

   task automatic step(input logic t);
      trigger_in = t;
      @(posedge clk);
      @(negedge clk);
      trigger_in = 1'b0;
   endtask

   function automatic int bit_at(input string s, input int i);
      if (i >= s.len()) return 0;
      return int'(s[i]) - 48;
   endfunction

   task automatic run_seq(input string nm, input string trg,
                          input string lvl, input string dn,
                          input string bsy, input string pnd,
                          input string ovf);
      for (int i = 0; i < lvl.len(); i++) begin
         step(bit_at(trg, i) != 0);
         check($sformatf("%s.level[%0d]", nm, i), int'(level_out), bit_at(lvl, i));
         check($sformatf("%s.done[%0d]", nm, i), int'(done), bit_at(dn, i));
         check($sformatf("%s.busy[%0d]", nm, i), int'(busy), bit_at(bsy, i));
         check($sformatf("%s.pend[%0d]", nm, i), int'(pending), bit_at(pnd, i));
         check($sformatf("%s.ovf[%0d]", nm, i), int'(overflow), bit_at(ovf, i));
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("rst_held");
      rst = 1'b0;
      @(negedge clk);
      check_idle("rst_rel");
      for (int i = 0; i < 20; i++) step(1'b0);
      check_idle("idle20");

      run_seq("single", "1",
              "1111000000",
              "0000100000",
              "1111110000",
              "0000000000",
              "0000000000");

`ifndef PULSE_STRETCHER_RETRIGGER_EN
      run_seq("three", "111",
              "11110011110011110000",
              "00001000001000001000",
              "11111111111111111100",
              "01222211111100000000",
              "00000000000000000000");

      run_seq("four", "1111",
              "11110011110011110000",
              "00001000001000001000",
              "11111111111111111100",
              "01222211111100000000",
              "00010000000000000000");

      run_seq("gapend", "1100001",
              "11110011110011110000",
              "00001000001000001000",
              "11111111111111111100",
              "01111111111100000000",
              "00000000000000000000");
`endif

      run_seq("consume", "1000001",
              "11110011110000",
              "00001000001000",
              "11111111111100",
              "00000000000000",
              "00000000000000");

`ifdef PULSE_STRETCHER_RETRIGGER_EN
      run_seq("retrig", "101",
              "1111110000",
              "0000001000",
              "1111111100",
              "0000000000",
              "0000000000");

      step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      check("pre_rst.level", int'(level_out), 1);
      rst = 1'b1;
      #1;
      check("async_rst.level", int'(level_out), 0);
      check("async_rst.busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0);
         check_idle($sformatf("post_rst[%0d]", i));
      end
`else
      step(1'b1);
      step(1'b1);
      step(1'b0);
      check("pre_rst.pend", int'(pending), 1);
      rst = 1'b1;
      #1;
      check("async_rst.level", int'(level_out), 0);
      check("async_rst.busy", int'(busy), 0);
      check("async_rst.pend", int'(pending), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0);
         check_idle($sformatf("post_rst[%0d]", i));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
